// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Also holds the per-operand forwarding priority function.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TRAP     = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // EX/MEM beats MEM/WB because it holds the younger write; $0 is never forwarded
    function automatic logic [1:0] fwd_select(
        input logic [REG_W-1:0] src,
        input logic             mem_we,
        input logic [REG_W-1:0] mem_rd,
        input logic             wb_we,
        input logic [REG_W-1:0] wb_rd
    );
        logic [1:0] sel;
        if ((src != {REG_W{1'b0}}) && mem_we && (mem_rd == src)) begin
            sel = FWD_EXMEM;
        end else if ((src != {REG_W{1'b0}}) && wb_we && (wb_rd == src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline status inputs and hazard-control outputs.
// The master side drives pipeline status; the slave side is the controller.
interface pipeline_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch_taken;
    logic             mem_regwrite;
    logic [REG_W-1:0] mem_rd;
    logic             wb_regwrite;
    logic [REG_W-1:0] wb_rd;
    logic             mem_access;
    logic             dmem_ack;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             dmem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_memread,
               ex_rd, ex_branch_taken, mem_regwrite, mem_rd, wb_regwrite, wb_rd,
               mem_access, dmem_ack,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               memwb_bubble, fwd_a, fwd_b, dmem_req, mem_err, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_memread,
               ex_rd, ex_branch_taken, mem_regwrite, mem_rd, wb_regwrite, wb_rd,
               mem_access, dmem_ack,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               memwb_bubble, fwd_a, fwd_b, dmem_req, mem_err, stall_cycles
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// EX-stage operand forwarding selects for ALU inputs A (rs) and B (rt).
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    // Independent priority select per operand
    always_comb begin
        fwd_a = fwd_select(ex_rs, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
        fwd_b = fwd_select(ex_rt, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: stage enables/flushes, forwarding, and the
// data-memory wait handshake with a timeout trap that only reset can clear.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_e            state_r;
    state_e            state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic [CNT_W-1:0]  stall_cycles_r;
    logic [CNT_W-1:0]  stall_cycles_nxt_s;
    logic              mem_err_r;
    logic              mem_err_nxt_s;

    logic              mem_stall_s;
    logic              load_use_s;
    logic              timeout_s;
    logic              pc_en_s;
    logic              ifid_en_s;
    logic              idex_en_s;
    logic              exmem_en_s;
    logic              ifid_flush_s;
    logic              idex_flush_s;
    logic              memwb_bubble_s;
    logic              dmem_req_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;

    pipe_fwd_unit u_fwd (
        .ex_rs        (bus.ex_rs),
        .ex_rt        (bus.ex_rt),
        .mem_regwrite (bus.mem_regwrite),
        .mem_rd       (bus.mem_rd),
        .wb_regwrite  (bus.wb_regwrite),
        .wb_rd        (bus.wb_rd),
        .fwd_a        (fwd_a_s),
        .fwd_b        (fwd_b_s)
    );

    // Hazard detection terms
    always_comb begin
        mem_stall_s = (state_r != TRAP) && bus.mem_access && !bus.dmem_ack;
        load_use_s  = bus.ex_memread && (bus.ex_rd != {REG_W{1'b0}}) &&
                      ((bus.id_uses_rs && (bus.ex_rd == bus.id_rs)) ||
                       (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
        timeout_s   = (wait_cnt_r >= WAIT_LAST);
    end

    // Next-state, wait counter and trap flag
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        mem_err_nxt_s  = mem_err_r;
        case (state_r)
            RUN, MEM_WAIT: begin
                if (mem_stall_s) begin
                    state_nxt_s    = timeout_s ? TRAP : MEM_WAIT;
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                    mem_err_nxt_s  = mem_err_r | timeout_s;
                end else begin
                    state_nxt_s    = RUN;
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                end
            end
            TRAP: begin
                state_nxt_s   = TRAP;
                mem_err_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s    = RUN;
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Stage controls in priority order: reset, trap, memory stall, branch, load-use
    always_comb begin
        pc_en_s        = 1'b1;
        ifid_en_s      = 1'b1;
        idex_en_s      = 1'b1;
        exmem_en_s     = 1'b1;
        ifid_flush_s   = 1'b0;
        idex_flush_s   = 1'b0;
        memwb_bubble_s = 1'b0;
        dmem_req_s     = 1'b0;
        if (rst) begin
            pc_en_s    = 1'b0;
            ifid_en_s  = 1'b0;
            idex_en_s  = 1'b0;
            exmem_en_s = 1'b0;
        end else if (state_r == TRAP) begin
            pc_en_s        = 1'b0;
            ifid_en_s      = 1'b0;
            idex_en_s      = 1'b0;
            exmem_en_s     = 1'b0;
            memwb_bubble_s = 1'b1;
        end else if (mem_stall_s) begin
            pc_en_s        = 1'b0;
            ifid_en_s      = 1'b0;
            idex_en_s      = 1'b0;
            exmem_en_s     = 1'b0;
            memwb_bubble_s = 1'b1;
            dmem_req_s     = 1'b1;
        end else if (bus.ex_branch_taken) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
            dmem_req_s   = bus.mem_access;
        end else if (load_use_s) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_flush_s = 1'b1;
            dmem_req_s   = bus.mem_access;
        end else begin
            dmem_req_s = bus.mem_access;
        end
    end

    // Saturating count of cycles with the PC frozen
    always_comb begin
        if (!pc_en_s && (stall_cycles_r != CNT_MAX)) begin
            stall_cycles_nxt_s = stall_cycles_r + CNT_W'(1);
        end else begin
            stall_cycles_nxt_s = stall_cycles_r;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= RUN;
            wait_cnt_r     <= {WAIT_W{1'b0}};
            stall_cycles_r <= {CNT_W{1'b0}};
            mem_err_r      <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            wait_cnt_r     <= wait_cnt_nxt_s;
            stall_cycles_r <= stall_cycles_nxt_s;
            mem_err_r      <= mem_err_nxt_s;
        end
    end

    assign bus.pc_en        = pc_en_s;
    assign bus.ifid_en      = ifid_en_s;
    assign bus.idex_en      = idex_en_s;
    assign bus.exmem_en     = exmem_en_s;
    assign bus.ifid_flush   = ifid_flush_s;
    assign bus.idex_flush   = idex_flush_s;
    assign bus.memwb_bubble = memwb_bubble_s;
    assign bus.dmem_req     = dmem_req_s;
    assign bus.fwd_a        = rst ? FWD_RF : fwd_a_s;
    assign bus.fwd_b        = rst ? FWD_RF : fwd_b_s;
    assign bus.mem_err      = mem_err_r;
    assign bus.stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for the combinational
// hazard/forwarding logic plus sequences for memory wait, timeout trap and reset.
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(4)) bus ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic [4:0] ex_rd;
        logic       memread;
        logic       br;
        logic       mem_we;
        logic [4:0] mem_rd;
        logic       wb_we;
        logic [4:0] wb_rd;
        logic [3:0] exp_en;
        logic [1:0] exp_fl;
        logic       exp_bub;
        logic [1:0] exp_fa;
        logic [1:0] exp_fb;
    } vec_t;

    vec_t vecs[13];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ctrl(input string name, input logic [3:0] en, input logic [1:0] fl,
                              input logic bub);
        check({name, "/en"}, 32'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en}), 32'(en));
        check({name, "/flush"}, 32'({bus.ifid_flush, bus.idex_flush}), 32'(fl));
        check({name, "/bubble"}, 32'(bus.memwb_bubble), 32'(bub));
    endtask

    task automatic idle_inputs();
        bus.id_rs = 5'd0;  bus.id_rt = 5'd0;  bus.id_uses_rs = 1'b0;  bus.id_uses_rt = 1'b0;
        bus.ex_rs = 5'd0;  bus.ex_rt = 5'd0;  bus.ex_rd = 5'd0;       bus.ex_memread = 1'b0;
        bus.ex_branch_taken = 1'b0;  bus.mem_regwrite = 1'b0;  bus.mem_rd = 5'd0;
        bus.wb_regwrite = 1'b0;      bus.wb_rd = 5'd0;
        bus.mem_access = 1'b0;       bus.dmem_ack = 1'b0;
    endtask

    // Pulse reset for half a cycle, return just after the next rising edge
    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        //                name         id_rs  id_rt  urs   urt   ex_rs  ex_rt  ex_rd  mrd   br    mwe   mem_rd wwe   wb_rd  en       fl     bub   fa     fb
        vecs[0]  = '{"idle",      5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  4'b1111, 2'b00, 1'b0, 2'b00, 2'b00};
        vecs[1]  = '{"lu_rs",     5'd5,  5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  4'b0011, 2'b01, 1'b0, 2'b00, 2'b00};
        vecs[2]  = '{"lu_rd0",    5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  4'b1111, 2'b00, 1'b0, 2'b00, 2'b00};
        vecs[3]  = '{"lu_rt",     5'd0,  5'd9,  1'b0, 1'b1, 5'd0,  5'd0,  5'd9,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  4'b0011, 2'b01, 1'b0, 2'b00, 2'b00};
        vecs[4]  = '{"lu_unused", 5'd5,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  4'b1111, 2'b00, 1'b0, 2'b00, 2'b00};
        vecs[5]  = '{"lu_noload", 5'd5,  5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd5,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  4'b1111, 2'b00, 1'b0, 2'b00, 2'b00};
        vecs[6]  = '{"br_lu",     5'd5,  5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  4'b1111, 2'b11, 1'b0, 2'b00, 2'b00};
        vecs[7]  = '{"fwd_tie",   5'd0,  5'd0,  1'b0, 1'b0, 5'd7,  5'd3,  5'd0,  1'b0, 1'b0, 1'b1, 5'd7,  1'b1, 5'd7,  4'b1111, 2'b00, 1'b0, 2'b10, 2'b00};
        vecs[8]  = '{"fwd_wb",    5'd0,  5'd0,  1'b0, 1'b0, 5'd7,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd7,  1'b1, 5'd7,  4'b1111, 2'b00, 1'b0, 2'b01, 2'b00};
        vecs[9]  = '{"fwd_r0",    5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 5'd0,  4'b1111, 2'b00, 1'b0, 2'b00, 2'b00};
        vecs[10] = '{"fwd_both",  5'd0,  5'd0,  1'b0, 1'b0, 5'd12, 5'd12, 5'd0,  1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 5'd12, 4'b1111, 2'b00, 1'b0, 2'b10, 2'b10};
        vecs[11] = '{"fwd_split", 5'd0,  5'd0,  1'b0, 1'b0, 5'd4,  5'd6,  5'd0,  1'b0, 1'b0, 1'b1, 5'd6,  1'b1, 5'd4,  4'b1111, 2'b00, 1'b0, 2'b01, 2'b10};
        vecs[12] = '{"lu_fwd",    5'd0,  5'd9,  1'b0, 1'b1, 5'd3,  5'd0,  5'd9,  1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 5'd0,  4'b0011, 2'b01, 1'b0, 2'b10, 2'b00};

        // Reset state, with inputs that would otherwise stall, branch and forward
        rst = 1'b1;
        idle_inputs();
        bus.mem_access = 1'b1;  bus.ex_branch_taken = 1'b1;
        bus.ex_rs = 5'd7;  bus.mem_regwrite = 1'b1;  bus.mem_rd = 5'd7;
        #3;
        check_ctrl("rst", 4'b0000, 2'b00, 1'b0);
        check("rst/dmem_req", 32'(bus.dmem_req), 32'd0);
        check("rst/fwd_a", 32'(bus.fwd_a), 32'(FWD_RF));
        check("rst/mem_err", 32'(bus.mem_err), 32'd0);
        check("rst/stall_cycles", 32'(bus.stall_cycles), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Combinational hazard/forwarding table in RUN
        for (int i = 0; i < 13; i++) begin
            bus.id_rs = vecs[i].id_rs;          bus.id_rt = vecs[i].id_rt;
            bus.id_uses_rs = vecs[i].uses_rs;   bus.id_uses_rt = vecs[i].uses_rt;
            bus.ex_rs = vecs[i].ex_rs;          bus.ex_rt = vecs[i].ex_rt;
            bus.ex_rd = vecs[i].ex_rd;          bus.ex_memread = vecs[i].memread;
            bus.ex_branch_taken = vecs[i].br;
            bus.mem_regwrite = vecs[i].mem_we;  bus.mem_rd = vecs[i].mem_rd;
            bus.wb_regwrite = vecs[i].wb_we;    bus.wb_rd = vecs[i].wb_rd;
            @(negedge clk);
            check_ctrl(vecs[i].name, vecs[i].exp_en, vecs[i].exp_fl, vecs[i].exp_bub);
            check({vecs[i].name, "/fwd_a"}, 32'(bus.fwd_a), 32'(vecs[i].exp_fa));
            check({vecs[i].name, "/fwd_b"}, 32'(bus.fwd_b), 32'(vecs[i].exp_fb));
            check({vecs[i].name, "/dmem_req"}, 32'(bus.dmem_req), 32'd0);
            @(posedge clk); #1;
        end

        // Memory access acked after three wait cycles; branch ignored while frozen
        reset_dut();
        bus.mem_access = 1'b1;
        bus.ex_branch_taken = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_ctrl($sformatf("memwait%0d", c), 4'b0000, 2'b00, 1'b1);
            check($sformatf("memwait%0d/dmem_req", c), 32'(bus.dmem_req), 32'd1);
            @(posedge clk); #1;
        end
        bus.dmem_ack = 1'b1;
        bus.ex_branch_taken = 1'b0;
        @(negedge clk);
        check_ctrl("mem_ack", 4'b1111, 2'b00, 1'b0);
        check("mem_ack/dmem_req", 32'(bus.dmem_req), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check_ctrl("after_ack", 4'b1111, 2'b00, 1'b0);
        check("after_ack/stall_cycles", 32'(bus.stall_cycles), 32'd3);
        check("after_ack/mem_err", 32'(bus.mem_err), 32'd0);
        @(posedge clk); #1;
        bus.mem_access = 1'b1;
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        check_ctrl("zero_wait", 4'b1111, 2'b00, 1'b0);
        check("zero_wait/dmem_req", 32'(bus.dmem_req), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("zero_wait/stall_cycles", 32'(bus.stall_cycles), 32'd3);
        @(posedge clk); #1;

        // Never acked: trap after four stall cycles, late ack ignored, counter saturates
        reset_dut();
        bus.mem_access = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_ctrl($sformatf("tmo%0d", c), 4'b0000, 2'b00, 1'b1);
            check($sformatf("tmo%0d/dmem_req", c), 32'(bus.dmem_req), 32'd1);
            check($sformatf("tmo%0d/mem_err", c), 32'(bus.mem_err), 32'd0);
            @(posedge clk); #1;
        end
        bus.ex_branch_taken = 1'b1;
        @(negedge clk);
        check_ctrl("trap", 4'b0000, 2'b00, 1'b1);
        check("trap/dmem_req", 32'(bus.dmem_req), 32'd0);
        check("trap/mem_err", 32'(bus.mem_err), 32'd1);
        check("trap/stall_cycles", 32'(bus.stall_cycles), 32'd4);
        @(posedge clk); #1;
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check_ctrl("late_ack", 4'b0000, 2'b00, 1'b1);
        check("late_ack/dmem_req", 32'(bus.dmem_req), 32'd0);
        check("late_ack/mem_err", 32'(bus.mem_err), 32'd1);
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("sat/stall_cycles", 32'(bus.stall_cycles), 32'd15);
        check("sat/mem_err", 32'(bus.mem_err), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("trap_rst/mem_err", 32'(bus.mem_err), 32'd0);
        check("trap_rst/stall_cycles", 32'(bus.stall_cycles), 32'd0);
        check_ctrl("trap_rst", 4'b0000, 2'b00, 1'b0);
        rst = 1'b0;
        idle_inputs();
        #1;
        check_ctrl("trap_exit", 4'b1111, 2'b00, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("trap_exit/mem_err", 32'(bus.mem_err), 32'd0);
        check("trap_exit/stall_cycles", 32'(bus.stall_cycles), 32'd0);

        // Async reset in the middle of a wait drops the request before any clock edge
        reset_dut();
        bus.mem_access = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("wait_pre/dmem_req", 32'(bus.dmem_req), 32'd1);
        check("wait_pre/stall_cycles", 32'(bus.stall_cycles), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("wait_rst/dmem_req", 32'(bus.dmem_req), 32'd0);
        check("wait_rst/stall_cycles", 32'(bus.stall_cycles), 32'd0);
        rst = 1'b0;
        bus.mem_access = 1'b0;
        #1;
        check_ctrl("wait_rst_run", 4'b1111, 2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
